// File: rtl/synth_pkg.sv
// Shared types and constants for the additive voice: LUT geometry, FSM encodings, sine table generator.
// Latency: n/a (compile-time content only).
// Backpressure: n/a.
package synth_pkg;

    // Default sine LUT geometry: depth is 2**SINE_AW entries of SINE_W bits.
    localparam int SINE_AW = 8;
    localparam int SINE_W  = 8;

    // 2*pi in Q30 fixed point, used to build the sine table at elaboration.
    localparam longint TWO_PI_Q30 = 64'sd6746518852;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_ISSUE,
        FR_ACC,
        FR_SCALE,
        FR_OUT
    } fr_state_t;

    // Offset sine entry: 2**(w-1) + round(( 2**(w-1) - 1 ) * sin(2*pi*idx / 2**aw)).
    // Evaluated with a Q30 Taylor series over a quarter wave so the table is
    // pure integer arithmetic and identical across tools.
    function automatic int sine_entry(input int idx, input int aw, input int w);
        longint n;
        longint j;
        longint x;
        longint x2;
        longint term;
        longint s;
        longint amp;
        longint v;
        n = longint'(1) << aw;
        j = longint'(idx) % (n / 2);
        if (j > n / 4) begin
            j = n / 2 - j;
        end
        x    = (j * TWO_PI_Q30) / n;
        x2   = (x * x) >>> 30;
        term = x;
        s    = x;
        for (int t = 1; t < 12; t++) begin
            term = (term * x2) >>> 30;
            term = -term / longint'((2 * t) * (2 * t + 1));
            s    = s + term;
        end
        if (longint'(idx) >= n / 2) begin
            s = -s;
        end
        amp = (longint'(1) << (w - 1)) - 1;
        v   = (s * amp + (longint'(1) << 29)) >>> 30;
        return int'(v) + (1 << (w - 1));
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Synchronous offset-sine ROM, 2**LUT_AW x AMP_W, one read port.
// Latency: 1 cycle from i_addr to o_dat.
// Backpressure: none; a new address may be presented every cycle.
// Ports: i_clk clock, i_addr read address, o_dat registered table entry.
module sine_lut
    import synth_pkg::*;
#(
    parameter int LUT_AW = SINE_AW,
    parameter int AMP_W  = SINE_W
) (
    input  logic              i_clk,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [AMP_W-1:0]  o_dat
);

    localparam int DEPTH = 1 << LUT_AW;

    logic [AMP_W-1:0] w_rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [AMP_W-1:0] ENTRY = AMP_W'(sine_entry(gi, LUT_AW, AMP_W));
        assign w_rom[gi] = ENTRY;
    end

    // Output register only; no reset so the table can map onto block RAM.
    logic [AMP_W-1:0] r_dat;

    always_ff @(posedge i_clk) begin
        r_dat <= w_rom[i_addr];
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/additive_voice.sv
// Additive voice: N_HARM harmonics of one phase accumulator through a shared sine LUT, scaled by an A/S/R envelope.
// Latency: sample_valid pulses N_HARM+3 cycles after each sample tick; one sample every DIV cycles while a note sounds.
// Backpressure: none; sample holds between sample_valid pulses and the consumer must take it within DIV cycles.
// Ports: CLK100MHZ clock, ck_rst async active-low reset, note_on key level, tune_word fundamental increment,
//        harm_en harmonic enables, sample/sample_valid PCM output, active envelope busy, env_level envelope value.
module additive_voice
    import synth_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int SAMPLE_HZ = 48000,
    parameter int N_HARM    = 5,
    parameter int PHASE_W   = 24,
    parameter int LUT_AW    = SINE_AW,
    parameter int AMP_W     = SINE_W,
    parameter int ENV_DIV   = 64
) (
    input  logic                    CLK100MHZ,
    input  logic                    ck_rst,
    input  logic                    note_on,
    input  logic [PHASE_W-1:0]      tune_word,
    input  logic [N_HARM-1:0]       harm_en,
    output logic [AMP_W+N_HARM-1:0] sample,
    output logic                    sample_valid,
    output logic                    active,
    output logic [7:0]              env_level
);

    localparam int DIV    = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ENV_CW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam int HK_W   = (N_HARM > 1) ? $clog2(N_HARM) : 1;
    localparam int ACC_W  = AMP_W + N_HARM;

    // ---------------- sample tick ----------------
    logic [DIV_CW-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == '0);

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == DIV_CW'(DIV - 1)) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + DIV_CW'(1);
        end
    end

    // ---------------- envelope and phase ----------------
    env_state_t         r_env_state;
    env_state_t         w_env_state_nxt;
    logic [7:0]         r_env;
    logic [7:0]         w_env_nxt;
    logic [ENV_CW-1:0]  r_env_cnt;
    logic               w_env_step;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nxt;

    assign w_env_step = (r_env_cnt == ENV_CW'(ENV_DIV - 1));

    // Key transitions win over level steps; a step is only taken when the
    // state is otherwise unchanged on this tick.
    always_comb begin
        w_env_state_nxt = r_env_state;
        w_env_nxt       = r_env;
        case (r_env_state)
            ENV_IDLE: begin
                if (note_on) begin
                    w_env_state_nxt = ENV_ATTACK;
                end
            end
            ENV_ATTACK: begin
                if (!note_on) begin
                    w_env_state_nxt = ENV_RELEASE;
                end else if (w_env_step) begin
                    if (r_env != 8'hFF) begin
                        w_env_nxt = r_env + 8'd1;
                    end
                    if (w_env_nxt == 8'hFF) begin
                        w_env_state_nxt = ENV_SUSTAIN;
                    end
                end
            end
            ENV_SUSTAIN: begin
                if (!note_on) begin
                    w_env_state_nxt = ENV_RELEASE;
                end
            end
            ENV_RELEASE: begin
                if (note_on) begin
                    w_env_state_nxt = ENV_ATTACK;
                end else if (w_env_step) begin
                    if (r_env != 8'h00) begin
                        w_env_nxt = r_env - 8'd1;
                    end
                    if (w_env_nxt == 8'h00) begin
                        w_env_state_nxt = ENV_IDLE;
                    end
                end
            end
            default: w_env_state_nxt = ENV_IDLE;
        endcase
    end

    // Phase stays parked at zero while silent so every note starts in phase.
    assign w_phase_nxt = (r_env_state == ENV_IDLE) ? '0 : (r_phase + tune_word);

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_env_state <= ENV_IDLE;
            r_env       <= '0;
            r_env_cnt   <= '0;
            r_phase     <= '0;
        end else if (w_tick) begin
            r_env_state <= w_env_state_nxt;
            r_env       <= w_env_nxt;
            r_phase     <= w_phase_nxt;
            if ((w_env_state_nxt != r_env_state) || w_env_step) begin
                r_env_cnt <= '0;
            end else begin
                r_env_cnt <= r_env_cnt + ENV_CW'(1);
            end
        end
    end

    // ---------------- frame sequencer ----------------
    fr_state_t          r_fr_state;
    logic [PHASE_W-1:0] r_hp;
    logic [HK_W-1:0]    r_k;
    logic               r_rd_vld;
    logic [HK_W-1:0]    r_rd_k;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_sample;
    logic               r_sample_vld;
    logic               w_fr_start;
    logic [LUT_AW-1:0]  w_lut_addr;
    logic [AMP_W-1:0]   w_lut_dat;
    logic [ACC_W+7:0]   w_prod;
    logic [ACC_W-1:0]   w_scaled;

    // Frames run whenever the envelope is, or is about to become, non-idle;
    // the tick that drops to idle still produces a final zero-level sample.
    assign w_fr_start = w_tick && ((r_env_state != ENV_IDLE) || (w_env_state_nxt != ENV_IDLE));
    assign w_lut_addr = r_hp[PHASE_W-1 -: LUT_AW];
    assign w_prod     = (ACC_W + 8)'(r_acc) * (ACC_W + 8)'(r_env);
    assign w_scaled   = ACC_W'(w_prod >> 8);

    sine_lut #(
        .LUT_AW (LUT_AW),
        .AMP_W  (AMP_W)
    ) u_sine_lut (
        .i_clk  (CLK100MHZ),
        .i_addr (w_lut_addr),
        .o_dat  (w_lut_dat)
    );

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_fr_state   <= FR_IDLE;
            r_hp         <= '0;
            r_k          <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_k       <= '0;
            r_acc        <= '0;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            // LUT data lags the issued address by one cycle; r_rd_* tracks
            // which harmonic is on the LUT output right now.
            r_rd_vld     <= (r_fr_state == FR_ISSUE);
            r_rd_k       <= r_k;
            r_sample_vld <= (r_fr_state == FR_SCALE);
            if (r_rd_vld && harm_en[r_rd_k]) begin
                r_acc <= r_acc + (ACC_W'(w_lut_dat) >> r_rd_k);
            end
            case (r_fr_state)
                FR_IDLE: begin
                    if (w_fr_start) begin
                        r_hp       <= w_phase_nxt;
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_fr_state <= FR_ISSUE;
                    end
                end
                FR_ISSUE: begin
                    // hp walks k*phase for k = 1..N_HARM.
                    r_hp <= r_hp + r_phase;
                    r_k  <= r_k + HK_W'(1);
                    if (r_k == HK_W'(N_HARM - 1)) begin
                        r_fr_state <= FR_ACC;
                    end
                end
                FR_ACC: begin
                    r_fr_state <= FR_SCALE;
                end
                FR_SCALE: begin
                    r_sample   <= w_scaled;
                    r_fr_state <= FR_OUT;
                end
                FR_OUT: begin
                    r_fr_state <= FR_IDLE;
                end
                default: begin
                    r_fr_state <= FR_IDLE;
                end
            endcase
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_vld;
    assign active       = (r_env_state != ENV_IDLE);
    assign env_level    = r_env;

endmodule

// File: tb/tb_additive_voice.sv
// Bench for additive_voice: randomized notes/tunes/harmonic masks against a sample-level reference model.
// Latency: the model expects each sample N_HARM+3 cycles after its tick.
// Backpressure: n/a.
module tb_additive_voice;

    localparam int CLK_HZ    = 768000;
    localparam int SAMPLE_HZ = 48000;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int N_HARM    = 5;
    localparam int PHASE_W   = 24;
    localparam int LUT_AW    = 8;
    localparam int AMP_W     = 8;
    localparam int ENV_DIV   = 1;
    localparam int FR_LAT    = N_HARM + 3;
    localparam longint PH_MOD = longint'(1) << PHASE_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    note_on;
    logic [PHASE_W-1:0]      tune_word;
    logic [N_HARM-1:0]       harm_en;
    logic [AMP_W+N_HARM-1:0] sample;
    logic                    sample_valid;
    logic                    active;
    logic [7:0]              env_level;

    always #5 clk = ~clk;

    additive_voice #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .N_HARM    (N_HARM),
        .PHASE_W   (PHASE_W),
        .LUT_AW    (LUT_AW),
        .AMP_W     (AMP_W),
        .ENV_DIV   (ENV_DIV)
    ) dut (
        .CLK100MHZ    (clk),
        .ck_rst       (rst_n),
        .note_on      (note_on),
        .tune_word    (tune_word),
        .harm_en      (harm_en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .active       (active),
        .env_level    (env_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference sine table straight from the real-valued definition.
    int lut [1 << LUT_AW];

    // Model state: 0 idle, 1 attack, 2 sustain, 3 release.
    int     m_state;
    int     m_env;
    int     m_cnt;
    longint m_phase;
    int     m_sample;
    int     m_cyc;
    int     due_q[$];
    int     val_q[$];

    task automatic model_reset();
        m_state  = 0;
        m_env    = 0;
        m_cnt    = 0;
        m_phase  = 0;
        m_sample = 0;
        m_cyc    = 0;
        due_q.delete();
        val_q.delete();
    endtask

    task automatic model_tick(input bit note, input int tune, input int harm);
        int     ns;
        int     ne;
        bit     step;
        bit     run;
        longint pn;
        longint acc;
        ns   = m_state;
        ne   = m_env;
        step = (m_cnt == ENV_DIV - 1);
        if (m_state == 0 && note) ns = 1;
        else if (m_state == 1 && !note) ns = 3;
        else if (m_state == 2 && !note) ns = 3;
        else if (m_state == 3 && note) ns = 1;
        else if (m_state == 1 && step) begin
            ne = (m_env < 255) ? m_env + 1 : 255;
            if (ne == 255) ns = 2;
        end else if (m_state == 3 && step) begin
            ne = (m_env > 0) ? m_env - 1 : 0;
            if (ne == 0) ns = 0;
        end
        m_cnt = ((ns != m_state) || step) ? 0 : m_cnt + 1;
        run   = (m_state != 0) || (ns != 0);
        pn    = (m_state == 0) ? 0 : (m_phase + (longint'(tune) & (PH_MOD - 1))) % PH_MOD;
        m_phase = pn;
        m_state = ns;
        m_env   = ne;
        if (run) begin
            acc = 0;
            for (int k = 1; k <= N_HARM; k++) begin
                if (((harm >> (k - 1)) & 1) == 1)
                    acc += lut[int'(((longint'(k) * pn) % PH_MOD) >> (PHASE_W - LUT_AW))] >> (k - 1);
            end
            due_q.push_back(m_cyc + FR_LAT);
            val_q.push_back(int'((acc * ne) >> 8));
        end
    endtask

    task automatic cycle_check();
        bit exp_vld;
        exp_vld = (due_q.size() > 0) && (due_q[0] == m_cyc);
        if (exp_vld) begin
            m_sample = val_q[0];
            void'(due_q.pop_front());
            void'(val_q.pop_front());
        end
        check_eq("sample_valid", sample_valid, exp_vld);
        check_eq("sample", sample, m_sample);
        @(negedge clk);
        m_cyc++;
    endtask

    // Called at a tick negedge: check envelope, apply inputs, run one sample period.
    task automatic do_tick(input bit note, input int tune, input int harm);
        check_eq("env_level", env_level, m_env);
        check_eq("active", active, m_state != 0);
        note_on   = note;
        tune_word = tune[PHASE_W-1:0];
        harm_en   = harm[N_HARM-1:0];
        model_tick(note, tune, harm);
        repeat (DIV) cycle_check();
    endtask

    initial begin
        bit note;
        for (int i = 0; i < (1 << LUT_AW); i++)
            lut[i] = $rtoi($floor(127.0 * $sin(2.0 * 3.14159265358979323846 * i / (1 << LUT_AW)) + 0.5)) + 128;

        rst_n     = 1'b0;
        note_on   = 1'b0;
        tune_word = '0;
        harm_en   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_sample", sample, 0);
        check_eq("rst_valid", sample_valid, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_env", env_level, 0);
        rst_n = 1'b1;

        // Silent: no frames, no valid pulses.
        repeat (20) do_tick(1'b0, int'($urandom), int'($urandom_range(0, 31)));

        // Pure fundamental, 64-sample period, through attack into sustain.
        repeat (300) do_tick(1'b1, 1 << 18, 5'b00001);
        check_eq("sustain_env", env_level, 255);

        // All harmonics at full envelope.
        repeat (80) do_tick(1'b1, 1 << 18, 5'b11111);

        // Random tuning and harmonic masks.
        repeat (120) do_tick(1'b1, int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 31)));

        // Reset in the middle of the issue stage.
        note_on = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_sample", sample, 0);
        check_eq("midrst_valid", sample_valid, 0);
        check_eq("midrst_active", active, 0);
        check_eq("midrst_env", env_level, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Attack from zero with phase restarted, up to env 100.
        for (int g = 0; g < 400 && m_env < 100; g++)
            do_tick(1'b1, int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 31)));
        check_eq("retrig_peak_env", env_level, 100);

        // Release down to 60, then re-trigger and climb without a drop.
        for (int g = 0; g < 400 && m_env > 60; g++)
            do_tick(1'b0, int'($urandom_range(0, 24'hFFFFFF)), 5'b11111);
        check_eq("retrig_low_env", env_level, 60);
        repeat (30) do_tick(1'b1, 3 << 16, 5'b10101);
        check_eq("retrig_resume_env", env_level, 89);

        // Full release to idle, then a fresh note from phase zero.
        repeat (300) do_tick(1'b0, 1 << 18, 5'b11111);
        check_eq("release_env", env_level, 0);
        check_eq("release_active", active, 0);
        repeat (10) do_tick(1'b1, 1 << 18, 5'b00001);

        // Random key toggling.
        note = 1'b1;
        repeat (200) begin
            if ($urandom_range(0, 15) == 0) note = ~note;
            do_tick(note, int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/additive_voice.md
# additive_voice

Parametrised successor to the fixed five-sine button synth: one voice built from N_HARM harmonics of a phase-accumulator fundamental, shaped by an attack/sustain/release envelope. A single shared sine LUT is time-multiplexed across the harmonics once per audio sample. It produces unsigned PCM samples with a valid strobe, and feeds the existing 8/9-bit PWM speaker path on the Arty jd header.

## Interface
- CLK_HZ, 100000000: system clock frequency.
- SAMPLE_HZ, 48000: sample rate. Sample divider DIV = CLK_HZ/SAMPLE_HZ (integer division). DIV must be greater than N_HARM+4.
- N_HARM, 5: harmonic count, 1..8. Harmonic k (1-based) runs at k times the fundamental.
- PHASE_W, 24: phase accumulator width.
- LUT_AW, 8: sine LUT address width. The LUT is addressed by phase[PHASE_W-1 -: LUT_AW].
- AMP_W, 8: LUT sample width, unsigned offset sine 0..2^AMP_W-1.
- ENV_DIV, 64: number of samples per envelope step.
- CLK100MHZ  in  1  system clock.
- ck_rst  in  1  reset, asynchronous, active-low.
- note_on  in  1  level; high = key held.
- tune_word  in  PHASE_W  fundamental phase increment per sample. It is latched at each sample tick.
- harm_en  in  N_HARM  bit k-1 enables harmonic k.
- sample  out  AMP_W+N_HARM  scaled voice output, unsigned.
- sample_valid  out  1  one-cycle pulse when sample updates.
- active  out  1  envelope state is not IDLE.
- env_level  out  8  current envelope value.

## Operation
- Tick counter: counts 0..DIV-1 and wraps. The tick pulse fires on count 0.
- Phase: on a tick, phase <= phase + tune_word. Wrap-around is modulo 2^PHASE_W. Phase is held at 0 while the envelope is IDLE.
- Frame sequencer states:
  - FR_IDLE: waits for a tick, then loads hp <= new phase and acc <= 0, and goes to FR_ISSUE.
  - FR_ISSUE: runs N_HARM cycles. Cycle k drives the LUT address from hp, then sets hp <= hp + phase. The address is therefore the top bits of k·phase mod 2^PHASE_W.
  - FR_ACC: the LUT has 1-cycle latency, so accumulation overlaps the issue stage by one cycle. Each returned harmonic adds acc += harm_en[k-1] ? (lut >> (k-1)) : 0.
  - FR_SCALE: sample <= (acc * env_level) >> 8.
  - FR_OUT: pulses sample_valid, then returns to FR_IDLE.
- acc width is AMP_W+N_HARM, so the sum cannot overflow.
- Envelope FSM, evaluated on every ENV_DIV-th sample tick (env step):
  - IDLE: if note_on, go to ATTACK.
  - ATTACK: env+1 per step. At 255 go to SUSTAIN. If note_on falls, go to RELEASE and keep the current env.
  - SUSTAIN: hold 255. If note_on falls, go to RELEASE.
  - RELEASE: env-1 per step. At 0 go to IDLE. If note_on rises, go to ATTACK from the current env (re-trigger without a click).
- State transitions on note_on are evaluated every tick. Only env increments and decrements wait for an env step.
- The env step counter resets on any state change.
- env saturates at 0 and 255 and never wraps.

## Timing
- Reset values:
  - sample = 0, sample_valid = 0, active = 0, env_level = 0.
  - phase = 0, tick counter = 0.
  - Both FSMs in IDLE / FR_IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts the frame and no sample_valid is produced.
- Latency: sample_valid rises exactly N_HARM+3 cycles after the tick cycle.
- sample holds its value between pulses. It is registered, with no combinational path from inputs.
- A tune_word or harm_en change takes effect from the next tick. harm_en is sampled at the accumulate stage.
- sample_valid period is exactly DIV cycles.

## Structure
- Shared package synth_pkg:
  - sine LUT depth/width localparams.
  - envelope state enum: ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE.
  - frame state enum.
- Sub-module sine_lut: synchronous 2^LUT_AW × AMP_W ROM with offset sine, one read port, 1-cycle latency, initialised from a generated table.
- The multiply in FR_SCALE is a single registered (AMP_W+N_HARM)×8 product.

## Test plan
- Reset: hold ck_rst=0 then release with note_on=0 → sample=0, active=0, and no sample_valid pulses before a note.
- Pitch: DIV=16, N_HARM=5, ENV_DIV=1, tune_word=2^18, harm_en=5'b00001, note_on=1 → fundamental period is 64 samples. After SUSTAIN, sample equals (lut[4·n mod 256]·255)>>8, and sample_valid arrives every 16 cycles, 8 cycles after each tick.
- Harmonics: tune_word=2^18, harm_en=5'b11111, env held at 255 → each sample equals the sum over k of lut[(4·n·k) mod 256]>>(k-1), scaled by 255/256. Max sample ≤ 483.
- Envelope: ENV_DIV=1, note_on held → env_level ramps 0→255 over 255 steps, then SUSTAIN. Drop note_on → env_level falls to 0 over 255 steps, then active=0 and phase=0.
- Re-trigger: release at env=100, then raise note_on when env=60 → ATTACK resumes from 60 with no step back to 0.
- Mid-frame reset: assert ck_rst during FR_ISSUE → all outputs 0 asynchronously, and the next note starts from phase 0.
